dcache_burst_controller: RTL and testbench
==========================================

// Module: dcache_burst_controller
// PURPOSE
// - Next-generation L1 data-cache controller between pipeline MEM stage, tag/data array and main memory.
// - Write-back, write-allocate; block size and memory beat width parametrised.
// - Multi-beat writeback/refill through a line buffer; write-miss merge and re-lookup.
// - Optional hit/miss counters.
// PARAMETERS
// - ADDR_W       32  byte-address width
// - WORD_BYTES    4  bytes per pipeline word (WORD_W = 8*WORD_BYTES)
// - BLOCK_WORDS   4  words per cache block, power of 2, >=2
// - BEAT_WORDS    1  words per memory beat; divides BLOCK_WORDS; BEATS = BLOCK_WORDS/BEAT_WORDS
// PORTS
// - clock            in   1                clock; all state on rising edge
// - reset            in   1                synchronous, active-high reset
// - ren, wen         in   1                pipeline load/store request; never both high
// - addr             in   ADDR_W           byte address
// - byteSelectVector in   WORD_BYTES       store byte enables
// - din              in   WORD_W           store data
// - stall            out  1                pipeline must hold request
// - dout             out  WORD_W           load data, valid when ren && !stall
// - cacheHit         in   1                tag match for BlockAddr (combinational)
// - cacheDirtyBit    in   1                victim line dirty
// - cacheVictimAddr  in   block-addr width victim block address
// - cacheDout        in   BLOCK_WORDS*WORD_W  selected line data
// - BlockAddr        out  block-addr width addr[ADDR_W-1:log2(BLOCK_WORDS*WORD_BYTES)]
// - cacheEn, cacheWen, cacheMemWen  out 1  array enable, byte write, full-line install
// - cacheBytesAccess out  BLOCK_WORDS*WORD_BYTES  byte strobes into line
// - cacheDin         out  BLOCK_WORDS*WORD_W  line write data
// - memRen, memWen   out  1                read/write request; held until transfer ends
// - memAddr          out  block-addr width victim addr in WB, BlockAddr otherwise
// - memDin           out  BEAT_WORDS*WORD_W   writeback beat
// - memWriteAck      in   1                current WB beat accepted
// - memReadValid     in   1                memDout beat valid
// - memDout          in   BEAT_WORDS*WORD_W   refill beat
// BEHAVIOUR
// - States: IDLE, WB, FILL, INSTALL, RELOOK. Reset -> IDLE, beat counter 0, line buffer cleared.
// - Reset outputs 0: stall, cacheEn/Wen/MemWen, memRen/Wen.
// - Reset is synchronous and dominates; mid-transfer it abandons beats, drops memRen/memWen next edge.
// - IDLE:
//   - req && hit: stall=0, cacheEn=1.
//   - Load: dout = word addr[word bits] of cacheDout, zero-latency.
//   - Store: cacheWen=1; cacheBytesAccess = byteSelectVector shifted to word slot; din replicated on cacheDin.
//   - req && !hit: stall=1 combinationally; next WB if dirty, else FILL.
//   - No req: all outputs 0.
// - WB: memWen=1; memDin = beat cnt of cacheDout; each memWriteAck increments cnt.
//   After ack on beat BEATS-1: cnt<=0, -> FILL.
// - FILL: memRen=1; each memReadValid stores memDout into buffer slot cnt, cnt++.
//   After beat BEATS-1 -> INSTALL. Beats are always in ascending order.
// - INSTALL (1 cycle): cacheEn=cacheMemWen=1; cacheBytesAccess all ones; cacheDin=buffer.
//   Pending store bytes merged into buffer here (store data wins). -> RELOOK.
// - RELOOK (1 cycle): stall=1, re-read array; -> IDLE, where request completes as a hit.
// - stall stays 1 from miss detection until the IDLE hit cycle; miss penalty = WB beats + FILL beats + 3.
// - ren/wen dropping while stalled is illegal; addr/din must hold.
// - memWriteAck/memReadValid outside WB/FILL ignored; both same cycle: only the one for current state counts.
// CONFIGURATION
// - DCACHE_PERF_CNT_EN defined: adds outputs hitCount, missCount, wbCount (32 bit each, wrap at 2^32).
//   Incremented on IDLE hit completion / miss detection / WB entry; cleared by reset.
//   RELOOK hit not counted as a hit.
// - Undefined: ports and counters absent; other behaviour identical.
// TESTING
// - Load hit: ren, addr=0x14, hit, cacheDout word1=0xDEADBEEF -> dout=0xDEADBEEF, stall=0 same cycle.
// - Store hit: wen, addr=0x06, bsv=4'b0011, din=0xAABB -> cacheWen=1, cacheBytesAccess=16'h00C0.
// - Clean load miss, BEATS=4: memRen held 4 valids; INSTALL writes full line; RELOOK; stall low after 7 cycles with zero-wait memory.
// - Dirty store miss: 4 WB beats from victim addr, then fill; INSTALL line shows store bytes merged.
// - Backpressure: memWriteAck low 3 cycles on beat 2 -> memDin/memWen held, cnt unchanged.
// - Reset in FILL after 2 beats -> next cycle IDLE, memRen=0, stall=0; DCACHE_PERF_CNT_EN counters=0.

Source files
------------

// File: rtl/dcache_burst_controller.sv
// Write-back, write-allocate L1 data-cache controller with multi-beat writeback/refill through a line buffer.
// Optional hit/miss/writeback counters are enabled by defining DCACHE_PERF_CNT_EN.
//
// state   | meaning
// IDLE    | serve hits with zero latency; detect miss
// WB      | stream dirty victim line to memory, one beat per memWriteAck
// FILL    | collect refill beats into the line buffer, one per memReadValid
// INSTALL | write buffered line (with pending store bytes merged) into the array
// RELOOK  | re-read array so the request completes as a hit in IDLE
module dcache_burst_controller #(
   parameter  int ADDR_W      = 32,
   parameter  int WORD_BYTES  = 4,
   parameter  int BLOCK_WORDS = 4,
   parameter  int BEAT_WORDS  = 1,
   localparam int WORD_W      = 8 * WORD_BYTES,
   localparam int LINE_BYTES  = BLOCK_WORDS * WORD_BYTES,
   localparam int LINE_W      = 8 * LINE_BYTES,
   localparam int BEAT_W      = BEAT_WORDS * WORD_W,
   localparam int OFF_W       = $clog2(LINE_BYTES),
   localparam int BLK_W       = ADDR_W - OFF_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ren,
   input  logic                  wen,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [WORD_BYTES-1:0] byteSelectVector,
   input  logic [WORD_W-1:0]     din,
   output logic                  stall,
   output logic [WORD_W-1:0]     dout,
   input  logic                  cacheHit,
   input  logic                  cacheDirtyBit,
   input  logic [BLK_W-1:0]      cacheVictimAddr,
   input  logic [LINE_W-1:0]     cacheDout,
   output logic [BLK_W-1:0]      BlockAddr,
   output logic                  cacheEn,
   output logic                  cacheWen,
   output logic                  cacheMemWen,
   output logic [LINE_BYTES-1:0] cacheBytesAccess,
   output logic [LINE_W-1:0]     cacheDin,
   output logic                  memRen,
   output logic                  memWen,
   output logic [BLK_W-1:0]      memAddr,
   output logic [BEAT_W-1:0]     memDin,
   input  logic                  memWriteAck,
   input  logic                  memReadValid,
   input  logic [BEAT_W-1:0]     memDout
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]           hitCount,
   output logic [31:0]           missCount,
   output logic [31:0]           wbCount
`endif
);

   localparam int BEATS  = BLOCK_WORDS / BEAT_WORDS;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BSEL_W = $clog2(WORD_BYTES);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_INSTALL, S_RELOOK} state_t;

   state_t             state;
   logic [CNT_W-1:0]   beat_cnt;
   logic [BEAT_W-1:0]  line_buf [BEATS];

   logic                      req;
   logic [OFF_W-BSEL_W-1:0]   word_sel;
   logic [OFF_W-1:0]          byte_off;
   logic [BSEL_W-1:0]         lane_off;
   logic [2*WORD_W-1:0]       din_dbl;
   logic [WORD_W-1:0]         din_rot;
   logic [LINE_BYTES-1:0]     store_strb;
   logic [LINE_W-1:0]         store_line;
   logic [LINE_W-1:0]         buf_line;
   logic [LINE_W-1:0]         install_line;

   assign req       = ren | wen;
   assign BlockAddr = addr[ADDR_W-1:OFF_W];
   assign word_sel  = addr[OFF_W-1:BSEL_W];
   assign byte_off  = addr[OFF_W-1:0];
   assign lane_off  = addr[BSEL_W-1:0];

   // Strobes and data are address-relative: lane 0 of the store lands on the addressed byte.
   assign din_dbl    = {din, din} << {lane_off, 3'b000};
   assign din_rot    = din_dbl[2*WORD_W-1:WORD_W];
   assign store_strb = LINE_BYTES'(byteSelectVector) << byte_off;
   assign store_line = {BLOCK_WORDS{din_rot}};

   always_comb begin
      buf_line = '0;
      for (int i = 0; i < BEATS; i++) buf_line[i*BEAT_W +: BEAT_W] = line_buf[i];
   end

   // Store data wins over refill data so the installed line already holds the write.
   always_comb begin
      install_line = buf_line;
      for (int b = 0; b < LINE_BYTES; b++) begin
         if (wen && store_strb[b]) install_line[b*8 +: 8] = store_line[b*8 +: 8];
      end
   end

   always_comb begin
      stall            = 1'b0;
      dout             = '0;
      cacheEn          = 1'b0;
      cacheWen         = 1'b0;
      cacheMemWen      = 1'b0;
      cacheBytesAccess = '0;
      cacheDin         = '0;
      memRen           = 1'b0;
      memWen           = 1'b0;
      memAddr          = BlockAddr;
      memDin           = '0;
      case (state)
         S_IDLE: begin
            if (!req) begin
               memAddr = '0;
            end else if (cacheHit) begin
               cacheEn = 1'b1;
               if (ren) dout = cacheDout[word_sel*WORD_W +: WORD_W];
               if (wen) begin
                  cacheWen         = 1'b1;
                  cacheBytesAccess = store_strb;
                  cacheDin         = store_line;
               end
            end else begin
               stall = 1'b1;
            end
         end
         S_WB: begin
            stall   = 1'b1;
            cacheEn = 1'b1;
            memWen  = 1'b1;
            memAddr = cacheVictimAddr;
            memDin  = cacheDout[beat_cnt*BEAT_W +: BEAT_W];
         end
         S_FILL: begin
            stall  = 1'b1;
            memRen = 1'b1;
         end
         S_INSTALL: begin
            stall            = 1'b1;
            cacheEn          = 1'b1;
            cacheMemWen      = 1'b1;
            cacheBytesAccess = '1;
            cacheDin         = install_line;
         end
         S_RELOOK: begin
            stall   = 1'b1;
            cacheEn = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         beat_cnt <= '0;
         for (int i = 0; i < BEATS; i++) line_buf[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               beat_cnt <= '0;
               if (req && !cacheHit) state <= cacheDirtyBit ? S_WB : S_FILL;
            end
            S_WB: begin
               if (memWriteAck) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     state    <= S_FILL;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            S_FILL: begin
               if (memReadValid) begin
                  line_buf[beat_cnt] <= memDout;
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     state    <= S_INSTALL;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            S_INSTALL: state <= S_RELOOK;
            S_RELOOK:  state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   // The IDLE completion right after RELOOK belongs to an already-counted miss.
   logic relook_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         relook_q  <= 1'b0;
         hitCount  <= '0;
         missCount <= '0;
         wbCount   <= '0;
      end else begin
         relook_q <= (state == S_RELOOK);
         if (state == S_IDLE && req) begin
            if (cacheHit) begin
               if (!relook_q) hitCount <= hitCount + 32'd1;
            end else begin
               missCount <= missCount + 32'd1;
               if (cacheDirtyBit) wbCount <= wbCount + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_burst_controller.sv
// Directed bench for dcache_burst_controller with a one-line array model and a simple memory responder.
// Counter checks are compiled in when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_burst_controller;

   logic         clock = 1'b0;
   logic         reset;
   logic         ren, wen;
   logic [31:0]  addr;
   logic [3:0]   byteSelectVector;
   logic [31:0]  din;
   logic         stall;
   logic [31:0]  dout;
   logic         cacheHit, cacheDirtyBit;
   logic [27:0]  cacheVictimAddr;
   logic [127:0] cacheDout;
   logic [27:0]  BlockAddr;
   logic         cacheEn, cacheWen, cacheMemWen;
   logic [15:0]  cacheBytesAccess;
   logic [127:0] cacheDin;
   logic         memRen, memWen;
   logic [27:0]  memAddr;
   logic [31:0]  memDin;
   logic         memWriteAck, memReadValid;
   logic [31:0]  memDout;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0]  hitCount, missCount, wbCount;
`endif

   int total = 0;
   int bad   = 0;

   dcache_burst_controller dut (
      .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
      .byteSelectVector(byteSelectVector), .din(din), .stall(stall), .dout(dout),
      .cacheHit(cacheHit), .cacheDirtyBit(cacheDirtyBit), .cacheVictimAddr(cacheVictimAddr),
      .cacheDout(cacheDout), .BlockAddr(BlockAddr), .cacheEn(cacheEn), .cacheWen(cacheWen),
      .cacheMemWen(cacheMemWen), .cacheBytesAccess(cacheBytesAccess), .cacheDin(cacheDin),
      .memRen(memRen), .memWen(memWen), .memAddr(memAddr), .memDin(memDin),
      .memWriteAck(memWriteAck), .memReadValid(memReadValid), .memDout(memDout)
`ifdef DCACHE_PERF_CNT_EN
      , .hitCount(hitCount), .missCount(missCount), .wbCount(wbCount)
`endif
   );

   always #5 clock = ~clock;

   // Single-line array model plus memory responder.
   logic [127:0] line_data;
   logic [27:0]  line_tag;
   logic         line_dirty;
   logic         preload_en = 1'b0;
   logic [127:0] preload_data;
   logic [27:0]  preload_tag;
   logic         preload_dirty;
   logic         rvalid_en;
   logic [1:0]   fill_beat;
   logic [1:0]   wb_beat;
   int           bp_cnt;
   logic [31:0]  wb_data [4];
   logic [27:0]  wb_addr;

   assign cacheHit        = (BlockAddr == line_tag);
   assign cacheDirtyBit   = line_dirty;
   assign cacheVictimAddr = line_tag;
   assign cacheDout       = line_data;
   assign memReadValid    = rvalid_en;
   assign memDout         = 32'hC0DE_0000 | {30'd0, fill_beat};
   assign memWriteAck     = memWen && !(wb_beat == 2'd2 && bp_cnt < 3);

   always @(posedge clock) begin
      if (preload_en) begin
         line_data  <= preload_data;
         line_tag   <= preload_tag;
         line_dirty <= preload_dirty;
      end else if (cacheMemWen) begin
         line_data  <= cacheDin;
         line_tag   <= BlockAddr;
         line_dirty <= 1'b0;
      end else if (cacheWen) begin
         for (int b = 0; b < 16; b++)
            if (cacheBytesAccess[b]) line_data[b*8 +: 8] <= cacheDin[b*8 +: 8];
         line_dirty <= 1'b1;
      end
      if (reset) begin
         fill_beat <= 2'd0;
         wb_beat   <= 2'd0;
         bp_cnt    <= 0;
      end else begin
         if (memRen && memReadValid) fill_beat <= fill_beat + 2'd1;
         if (memWen) begin
            if (memWriteAck) begin
               wb_data[wb_beat] <= memDin;
               wb_addr          <= memAddr;
               wb_beat          <= wb_beat + 2'd1;
            end else begin
               bp_cnt <= bp_cnt + 1;
            end
         end
      end
   end

   localparam logic [127:0] LINE0 = 128'h44444444_33333333_DEADBEEF_11111111;
   localparam logic [127:0] LINED = 128'h44444444_33333333_22222222_11111111;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic preload(input logic [27:0] tag, input logic [127:0] data, input logic dirty);
      preload_tag   = tag;
      preload_data  = data;
      preload_dirty = dirty;
      preload_en    = 1'b1;
      tick();
      preload_en    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ren = 1'b0; wen = 1'b0; rvalid_en = 1'b0;
      addr = '0; byteSelectVector = '0; din = '0;
      tick(); tick();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
      total++; if ({memRen, memWen} !== 2'b00) begin bad++; $display("FAIL reset_mem got=%b exp=00", {memRen, memWen}); end
      total++; if ({cacheEn, cacheWen, cacheMemWen} !== 3'b000) begin bad++; $display("FAIL reset_cache got=%b exp=000", {cacheEn, cacheWen, cacheMemWen}); end
      reset = 1'b0;
      tick();
      total++; if (dout !== 32'h0 || cacheBytesAccess !== 16'h0) begin bad++; $display("FAIL idle_noreq got=%h/%h exp=0/0", dout, cacheBytesAccess); end
`ifdef DCACHE_PERF_CNT_EN
      total++; if ({hitCount, missCount, wbCount} !== 96'h0) begin bad++; $display("FAIL reset_counters got=%h exp=0", {hitCount, missCount, wbCount}); end
`endif
   endtask

   task automatic test_load_hit();
      preload(28'h1, LINE0, 1'b0);
      ren = 1'b1; addr = 32'h14;
      #1;
      total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL load_hit_dout got=%h exp=deadbeef", dout); end
      total++; if (stall !== 1'b0 || cacheEn !== 1'b1 || cacheWen !== 1'b0) begin bad++; $display("FAIL load_hit_ctl got=%b%b%b exp=010", stall, cacheEn, cacheWen); end
      tick();
      ren = 1'b0;
   endtask

   task automatic test_store_hit();
      preload(28'h0, LINE0, 1'b0);
      wen = 1'b1; addr = 32'h06; byteSelectVector = 4'b0011; din = 32'h0000AABB;
      #1;
      total++; if (cacheWen !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL store_hit_ctl got=%b%b exp=10", cacheWen, stall); end
      total++; if (cacheBytesAccess !== 16'h00C0) begin bad++; $display("FAIL store_hit_strb got=%h exp=00c0", cacheBytesAccess); end
      total++; if (cacheDin[63:48] !== 16'hAABB) begin bad++; $display("FAIL store_hit_data got=%h exp=aabb", cacheDin[63:48]); end
      tick();
      wen = 1'b0; ren = 1'b1; addr = 32'h04;
      #1;
      total++; if (dout !== 32'hAABBBEEF) begin bad++; $display("FAIL store_then_load got=%h exp=aabbbeef", dout); end
      tick();
      ren = 1'b0;
   endtask

   task automatic test_clean_load_miss();
      int cyc, ren_cyc, wen_cyc, installs;
      logic [127:0] inst_din;
      logic [15:0]  inst_strb;
      logic [27:0]  fill_addr;
      cyc = 0; ren_cyc = 0; wen_cyc = 0; installs = 0;
      inst_din = '0; inst_strb = '0; fill_addr = '0;
      preload(28'h0, LINE0, 1'b0);
      rvalid_en = 1'b1; ren = 1'b1; addr = 32'h24;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL miss_stall_comb got=%b exp=1", stall); end
      while (stall === 1'b1 && cyc < 40) begin
         if (memRen) begin ren_cyc++; fill_addr = memAddr; end
         if (memWen) wen_cyc++;
         if (cacheMemWen) begin installs++; inst_din = cacheDin; inst_strb = cacheBytesAccess; end
         tick();
         cyc++;
      end
      total++; if (cyc != 7) begin bad++; $display("FAIL clean_miss_latency got=%0d exp=7", cyc); end
      total++; if (ren_cyc != 4 || wen_cyc != 0) begin bad++; $display("FAIL clean_miss_beats got=%0d/%0d exp=4/0", ren_cyc, wen_cyc); end
      total++; if (fill_addr !== 28'h2) begin bad++; $display("FAIL clean_miss_addr got=%h exp=2", fill_addr); end
      total++; if (installs != 1 || inst_strb !== 16'hFFFF) begin bad++; $display("FAIL clean_miss_install got=%0d/%h exp=1/ffff", installs, inst_strb); end
      total++; if (inst_din !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin bad++; $display("FAIL clean_miss_line got=%h", inst_din); end
      total++; if (dout !== 32'hC0DE0001 || memRen !== 1'b0) begin bad++; $display("FAIL clean_miss_dout got=%h/%b exp=c0de0001/0", dout, memRen); end
      tick();
      ren = 1'b0; rvalid_en = 1'b0;
   endtask

   task automatic test_dirty_store_miss();
      int cyc, bp;
      logic [127:0] inst_din;
      cyc = 0; bp = 0; inst_din = '0;
      preload(28'h3, LINED, 1'b1);
      rvalid_en = 1'b1; wen = 1'b1; addr = 32'h58; byteSelectVector = 4'hF; din = 32'h5A5AA5A5;
      #1;
      while (stall === 1'b1 && cyc < 60) begin
         if (memWen && !memWriteAck) begin
            bp++;
            total++; if (memDin !== 32'h33333333) begin bad++; $display("FAIL backpressure_hold got=%h exp=33333333", memDin); end
         end
         if (cacheMemWen) inst_din = cacheDin;
         tick();
         cyc++;
      end
      total++; if (cyc != 14) begin bad++; $display("FAIL dirty_miss_latency got=%0d exp=14", cyc); end
      total++; if (bp != 3) begin bad++; $display("FAIL backpressure_cycles got=%0d exp=3", bp); end
      total++; if ({wb_data[3], wb_data[2], wb_data[1], wb_data[0]} !== LINED) begin bad++; $display("FAIL wb_data got=%h %h %h %h", wb_data[3], wb_data[2], wb_data[1], wb_data[0]); end
      total++; if (wb_addr !== 28'h3) begin bad++; $display("FAIL wb_addr got=%h exp=3", wb_addr); end
      total++; if (inst_din !== 128'hC0DE0003_5A5AA5A5_C0DE0001_C0DE0000) begin bad++; $display("FAIL merged_line got=%h", inst_din); end
      total++; if (cacheWen !== 1'b1 || cacheBytesAccess !== 16'h0F00) begin bad++; $display("FAIL dirty_miss_complete got=%b/%h exp=1/0f00", cacheWen, cacheBytesAccess); end
      tick();
      wen = 1'b0; rvalid_en = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
      total++; if (hitCount !== 32'd3 || missCount !== 32'd2 || wbCount !== 32'd1) begin bad++; $display("FAIL counters got=%0d/%0d/%0d exp=3/2/1", hitCount, missCount, wbCount); end
`endif
   endtask

   task automatic test_reset_in_fill();
      preload(28'h0, LINE0, 1'b0);
      rvalid_en = 1'b1; ren = 1'b1; addr = 32'h70;
      tick(); tick(); tick();
      total++; if (memRen !== 1'b1 || memAddr !== 28'h7) begin bad++; $display("FAIL fill_before_reset got=%b/%h exp=1/7", memRen, memAddr); end
      reset = 1'b1; ren = 1'b0;
      tick();
      total++; if (memRen !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_in_fill got=%b/%b exp=0/0", memRen, stall); end
      total++; if (memWen !== 1'b0 || cacheMemWen !== 1'b0) begin bad++; $display("FAIL reset_in_fill_wr got=%b/%b exp=0/0", memWen, cacheMemWen); end
`ifdef DCACHE_PERF_CNT_EN
      total++; if ({hitCount, missCount, wbCount} !== 96'h0) begin bad++; $display("FAIL reset_in_fill_counters got=%h exp=0", {hitCount, missCount, wbCount}); end
`endif
      reset = 1'b0; rvalid_en = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      preload(28'h0, LINE0, 1'b0);
      wen = 1'b1; addr = 32'h0; byteSelectVector = 4'hF; din = 32'h12345678;
      #1;
      total++; if (stall !== 1'b0 || cacheBytesAccess !== 16'h000F) begin bad++; $display("FAIL b2b_store got=%b/%h exp=0/000f", stall, cacheBytesAccess); end
      tick();
      wen = 1'b0; ren = 1'b1;
      #1;
      total++; if (dout !== 32'h12345678 || stall !== 1'b0) begin bad++; $display("FAIL b2b_load got=%h/%b exp=12345678/0", dout, stall); end
      tick();
      ren = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
      total++; if (hitCount !== 32'd2 || missCount !== 32'd0 || wbCount !== 32'd0) begin bad++; $display("FAIL b2b_counters got=%0d/%0d/%0d exp=2/0/0", hitCount, missCount, wbCount); end
`endif
   endtask

   initial begin
      test_reset();
      test_load_hit();
      test_store_hit();
      test_clean_load_miss();
      test_dirty_store_miss();
      test_reset_in_fill();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
